// File: rtl/fetch_decode_unit_if.sv
// Instruction-memory read bus between the fetch/decode front end (master)
// and the instruction memory (slave).
interface fetch_decode_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
  modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end: reads two or three instruction words at the
// program counter, pulses pc_inc once per consumed word, latches the decoded
// fields and issues one single-cycle write strobe per instruction.
module fetch_decode_unit #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_decode_unit_if.master bus,
  input  logic                i_run,
  input  logic [31:0]         i_program_counter,
  output logic [2:0]          o_op,
  output logic                o_form,
  output logic [1:0]          o_vec,
  output logic [3:0]          o_alu_config,
  output logic [3:0]          o_A,
  output logic [3:0]          o_B,
  output logic [3:0]          o_C,
  output logic [3:0]          o_D,
  output logic [3:0]          o_Y1,
  output logic [3:0]          o_Y2,
  output logic [1:0]          o_write,
  output logic                o_const_c,
  output logic                o_pc_inc,
  output logic [31:0]         o_constant,
  output logic [3:0]          o_copy_select,
  output logic                o_issue,
  output logic                o_fault
);

  typedef enum logic [2:0] {
    F0_REQ, F0_INC, F1_REQ, F1_INC, K_REQ, K_INC, EXEC, HALT
  } state_t;

  // Counter value on the last allowed waiting cycle (unused when MEM_TIMEOUT=0).
  localparam logic [31:0] LP_TMO_LAST = 32'(MEM_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        w_req;
  logic        w_req_o;
  logic        w_ack;
  logic        w_exec;
  logic        w_inc;
  logic        w_tmo_last;
  logic        w_tmo_hit;
  logic [31:0] r_tmo_cnt;
  logic        r_fault;

  logic [2:0]  r_op;
  logic        r_form;
  logic [1:0]  r_vec;
  logic [1:0]  r_wr;
  logic        r_const_c;
  logic [3:0]  r_alu_config;
  logic [3:0]  r_copy_select;
  logic [3:0]  r_A, r_B, r_C, r_D, r_Y1, r_Y2;
  logic [31:0] r_constant;

  assign w_tmo_last = (MEM_TIMEOUT != 0) && (r_tmo_cnt == LP_TMO_LAST);
  // Request is forced low while reset is held so every output reads 0.
  assign w_req_o    = w_req & rst_n;
  assign w_ack      = w_req_o & bus.mem_ack;

  // Next-state and per-state strobes; an ack always beats a timeout.
  always_comb begin
    w_next    = r_state;
    w_req     = 1'b0;
    w_inc     = 1'b0;
    w_exec    = 1'b0;
    w_tmo_hit = 1'b0;
    case (r_state)
      F0_REQ: begin
        w_req = i_run;
        if (i_run) begin
          if (bus.mem_ack)     w_next = F0_INC;
          else if (w_tmo_last) begin w_next = HALT; w_tmo_hit = 1'b1; end
        end
      end
      F1_REQ: begin
        w_req = 1'b1;
        if (bus.mem_ack)     w_next = F1_INC;
        else if (w_tmo_last) begin w_next = HALT; w_tmo_hit = 1'b1; end
      end
      K_REQ: begin
        w_req = 1'b1;
        if (bus.mem_ack)     w_next = K_INC;
        else if (w_tmo_last) begin w_next = HALT; w_tmo_hit = 1'b1; end
      end
      F0_INC: begin
        w_inc  = 1'b1;
        w_next = F1_REQ;
      end
      F1_INC: begin
        w_inc  = 1'b1;
        w_next = r_const_c ? K_REQ : EXEC;
      end
      K_INC: begin
        w_inc  = 1'b1;
        w_next = EXEC;
      end
      EXEC: begin
        w_exec = 1'b1;
        w_next = F0_REQ;
      end
      HALT:    w_next = HALT;
      default: w_next = F0_REQ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= F0_REQ;
    else        r_state <= w_next;
  end

  // Wait counter: runs only while a request is outstanding, clears otherwise,
  // which also clears it on entry to every request state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_tmo_cnt <= '0;
    else if (w_req_o && !bus.mem_ack)  r_tmo_cnt <= r_tmo_cnt + 32'd1;
    else                               r_tmo_cnt <= '0;
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_fault <= 1'b0;
    else if (w_tmo_hit) r_fault <= 1'b1;
  end

  // Field registers: each word's fields load only on that word's ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= '0; r_form <= 1'b0; r_vec <= '0; r_wr <= '0; r_const_c <= 1'b0;
      r_alu_config <= '0; r_copy_select <= '0;
      r_A <= '0; r_B <= '0; r_C <= '0; r_D <= '0; r_Y1 <= '0; r_Y2 <= '0;
      r_constant <= '0;
    end else if (w_ack) begin
      if (r_state == F0_REQ) begin
        r_op          <= bus.mem_rdata[31:29];
        r_form        <= bus.mem_rdata[28];
        r_vec         <= bus.mem_rdata[27:26];
        r_wr          <= bus.mem_rdata[25:24];
        r_const_c     <= bus.mem_rdata[23];
        r_alu_config  <= bus.mem_rdata[22:19];
        r_copy_select <= bus.mem_rdata[18:15];
      end
      if (r_state == F1_REQ) begin
        r_A  <= bus.mem_rdata[31:28];
        r_B  <= bus.mem_rdata[27:24];
        r_C  <= bus.mem_rdata[23:20];
        r_D  <= bus.mem_rdata[19:16];
        r_Y1 <= bus.mem_rdata[15:12];
        r_Y2 <= bus.mem_rdata[11:8];
      end
      if (r_state == K_REQ) r_constant <= bus.mem_rdata;
    end
  end

  assign bus.mem_req    = w_req_o;
  assign bus.mem_addr   = w_req_o ? i_program_counter : 32'd0;
  assign o_pc_inc       = w_inc;
  assign o_issue        = w_exec;
  assign o_write        = w_exec ? r_wr : 2'b00;
  assign o_fault        = r_fault;
  assign o_op           = r_op;
  assign o_form         = r_form;
  assign o_vec          = r_vec;
  assign o_const_c      = r_const_c;
  assign o_alu_config   = r_alu_config;
  assign o_copy_select  = r_copy_select;
  assign o_A            = r_A;
  assign o_B            = r_B;
  assign o_C            = r_C;
  assign o_D            = r_D;
  assign o_Y1           = r_Y1;
  assign o_Y2           = r_Y2;
  assign o_constant     = r_constant;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit: a memory responder with per-request
// wait states, a PC register stepped by pc_inc, and a per-cycle expectation
// queue built from the instruction words in memory.
module tb_fetch_decode_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  always #5 clk = ~clk;

  fetch_decode_unit_if bus ();

  logic [31:0] pc = 32'h10;
  logic [2:0]  op;
  logic        form;
  logic [1:0]  vec;
  logic [3:0]  alu_config, A, B, C, D, Y1, Y2, copy_select;
  logic [1:0]  write;
  logic        const_c, pc_inc, issue, fault;
  logic [31:0] constant;

  fetch_decode_unit #(.MEM_TIMEOUT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .i_run(run), .i_program_counter(pc),
    .o_op(op), .o_form(form), .o_vec(vec), .o_alu_config(alu_config),
    .o_A(A), .o_B(B), .o_C(C), .o_D(D), .o_Y1(Y1), .o_Y2(Y2),
    .o_write(write), .o_const_c(const_c), .o_pc_inc(pc_inc), .o_constant(constant),
    .o_copy_select(copy_select), .o_issue(issue), .o_fault(fault)
  );

  // Memory responder: request number idx is acked after waits[idx] idle
  // cycles, and only the first nreq requests after reset are ever acked.
  logic [31:0] mem [0:255];
  int waits [0:15];
  int nreq = 0;
  int idx, wcnt;

  assign bus.mem_ack   = bus.mem_req && (idx < nreq) && (wcnt == waits[idx[3:0]]);
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= 0;
      wcnt <= 0;
    end else if (bus.mem_req) begin
      if (bus.mem_ack) begin idx <= idx + 1; wcnt <= 0; end
      else wcnt <= wcnt + 1;
    end
  end

  always @(posedge clk) if (pc_inc) pc <= pc + 32'd1;

  // Expectation model.
  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        inc;
    logic        iss;
    logic [1:0]  wr;
    logic        flt;
    logic        fld;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] k;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        ce;
  logic [31:0] m_addr;
  int          m_ridx;
  logic [31:0] exp_const;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic exp_t blank();
    exp_t e;
    e.req = 1'b0; e.addr = '0; e.inc = 1'b0; e.iss = 1'b0; e.wr = '0;
    e.flt = 1'b0; e.fld = 1'b0; e.w0 = '0; e.w1 = '0; e.k = '0;
    return e;
  endfunction

  // Every word: (waits+1) request cycles at its address, then one pc_inc
  // cycle; after the last word one issue cycle carrying the write bits.
  task automatic push_instr();
    logic [31:0] w0, w1;
    int nw;
    exp_t e;
    w0 = mem[m_addr[7:0]];
    w1 = mem[8'(m_addr + 32'd1)];
    nw = w0[23] ? 3 : 2;
    for (int k = 0; k < nw; k++) begin
      e = blank(); e.req = 1'b1; e.addr = m_addr + 32'(k);
      for (int c = 0; c <= waits[m_ridx + k]; c++) exp_q.push_back(e);
      e = blank(); e.inc = 1'b1;
      exp_q.push_back(e);
    end
    if (nw == 3) exp_const = mem[8'(m_addr + 32'd2)];
    e = blank(); e.iss = 1'b1; e.wr = w0[25:24]; e.fld = 1'b1;
    e.w0 = w0; e.w1 = w1; e.k = exp_const;
    exp_q.push_back(e);
    m_addr = m_addr + 32'(nw);
    m_ridx = m_ridx + nw;
  endtask

  task automatic push_plain(input int n, input logic req, input logic flt);
    exp_t e;
    e = blank(); e.req = req; e.addr = m_addr; e.flt = flt;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // Per-cycle compare, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      ce = exp_q.pop_front();
      chk("mem_req", 32'(bus.mem_req), 32'(ce.req));
      if (ce.req) chk("mem_addr", bus.mem_addr, ce.addr);
      chk("pc_inc", 32'(pc_inc), 32'(ce.inc));
      chk("issue", 32'(issue), 32'(ce.iss));
      chk("write", 32'(write), 32'(ce.wr));
      chk("fault", 32'(fault), 32'(ce.flt));
      if (ce.fld) begin
        chk("op", 32'(op), 32'(ce.w0[31:29]));
        chk("form", 32'(form), 32'(ce.w0[28]));
        chk("vec", 32'(vec), 32'(ce.w0[27:26]));
        chk("const_c", 32'(const_c), 32'(ce.w0[23]));
        chk("alu_config", 32'(alu_config), 32'(ce.w0[22:19]));
        chk("copy_select", 32'(copy_select), 32'(ce.w0[18:15]));
        chk("A", 32'(A), 32'(ce.w1[31:28]));
        chk("B", 32'(B), 32'(ce.w1[27:24]));
        chk("C", 32'(C), 32'(ce.w1[23:20]));
        chk("D", 32'(D), 32'(ce.w1[19:16]));
        chk("Y1", 32'(Y1), 32'(ce.w1[15:12]));
        chk("Y2", 32'(Y2), 32'(ce.w1[11:8]));
        chk("constant", constant, ce.k);
      end
    end
  end

  // Wait until every queued expectation has been checked, then step #1 past
  // the falling edge.
  task automatic drain(input int budget);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < budget) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
    #1;
  endtask

  task automatic restart_model();
    m_addr    = pc;
    m_ridx    = 0;
    exp_const = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 16; i++) waits[i] = 0;
    mem[8'h10] = 32'h2000_0000;  // op=1, write=00, no constant
    mem[8'h11] = 32'h1234_5600;
    mem[8'h12] = 32'h7BD2_8000;  // op=3, write=11, constant present
    mem[8'h13] = 32'hFEDC_BA00;
    mem[8'h14] = 32'hDEAD_BEEF;
    mem[8'h15] = 32'hA500_0000;  // op=5, write=01, no constant
    mem[8'h16] = 32'h0F1E_2D00;
    mem[8'h17] = 32'h4300_0000;  // op=2, write=11
    mem[8'h18] = 32'h9876_5400;
    mem[8'h19] = 32'hC100_0000;  // abandoned by reset after its W0
    mem[8'h1A] = 32'h3E00_0000;  // refetched as W0: op=1, write=10
    mem[8'h1B] = 32'h1357_9B00;

    // Reset state.
    run  = 1'b1;
    nreq = 2;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_issue", 32'(issue), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_constant", constant, 32'd0);
    chk("rst_op", 32'(op), 32'd0);

    // First instruction from PC 0x10, memory acking immediately.
    @(posedge clk); #1;
    rst_n = 1'b1;
    restart_model();
    push_instr();
    drain(100);
    run = 1'b0;
    chk("lit_op", 32'(op), 32'd1);
    chk("lit_A", 32'(A), 32'd1);
    chk("lit_B", 32'(B), 32'd2);
    chk("lit_C", 32'(C), 32'd3);
    chk("lit_D", 32'(D), 32'd4);
    chk("lit_Y1", 32'(Y1), 32'd5);
    chk("lit_Y2", 32'(Y2), 32'd6);
    chk("lit_pc_after_1", pc, 32'h12);

    // Constant instruction, then one with 3 wait states on its W1.
    nreq = 7;
    waits[6] = 3;
    @(posedge clk); #1;
    run = 1'b1;
    push_instr();
    push_instr();
    drain(100);
    run = 1'b0;
    chk("lit_constant_kept", constant, 32'hDEAD_BEEF);
    chk("lit_pc_after_3", pc, 32'h17);
    chk("lit_idle_write", 32'(write), 32'd0);

    // run=0 keeps the unit idle; reset has cleared the constant.
    rst_n = 1'b0;
    #1;
    chk("rst_constant_clr", constant, 32'd0);
    waits[6] = 0;
    nreq = 2;
    @(posedge clk); #1;
    rst_n = 1'b1;
    restart_model();
    push_plain(6, 1'b0, 1'b0);
    drain(50);
    @(posedge clk); #1;
    run = 1'b1;
    push_instr();
    drain(100);
    run = 1'b0;

    // Reset while waiting for W1: abandon the partial instruction.
    rst_n = 1'b0;
    nreq = 1;
    @(posedge clk); #1;
    run = 1'b1;
    rst_n = 1'b1;
    restart_model();
    push_plain(1, 1'b1, 1'b0);
    exp_q.push_back('{req: 1'b0, addr: 32'd0, inc: 1'b1, iss: 1'b0, wr: 2'd0,
                      flt: 1'b0, fld: 1'b0, w0: 32'd0, w1: 32'd0, k: 32'd0});
    m_addr = m_addr + 32'd1;
    push_plain(1, 1'b1, 1'b0);
    drain(50);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_req", 32'(bus.mem_req), 32'd0);
    chk("abort_pc_inc", 32'(pc_inc), 32'd0);
    chk("abort_issue", 32'(issue), 32'd0);
    chk("abort_write", 32'(write), 32'd0);
    chk("abort_op", 32'(op), 32'd0);
    chk("abort_const_c", 32'(const_c), 32'd0);
    chk("abort_pc", pc, 32'h1A);
    nreq = 2;
    @(posedge clk); #1;
    rst_n = 1'b1;
    restart_model();
    push_instr();
    drain(100);
    run = 1'b0;
    chk("lit_pc_after_resume", pc, 32'h1C);

    // Timeout: memory never acks.
    rst_n = 1'b0;
    nreq = 0;
    @(posedge clk); #1;
    run = 1'b1;
    rst_n = 1'b1;
    restart_model();
    push_plain(4, 1'b1, 1'b0);
    push_plain(6, 1'b0, 1'b1);
    drain(50);
    chk("tmo_fault", 32'(fault), 32'd1);
    chk("tmo_pc", pc, 32'h1C);
    rst_n = 1'b0;
    #1;
    chk("tmo_fault_clr", 32'(fault), 32'd0);
    run = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_unit.md
Name: fetch_decode_unit

Overview:
- Front end of the core: fetches instruction words from instruction memory at the program counter and drives the datapath's control bundle.
- Steps the PC by pulsing pc_inc once per consumed word.
- Issues exactly one single-cycle register-write strobe per instruction.
- Multi-word instructions: two mandatory words, plus an optional third constant word.

Parameters:
- MEM_TIMEOUT, 0, max cycles mem_req may wait for mem_ack before faulting; 0 disables timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  permits starting a new instruction fetch
- program_counter  in  32  current PC from the datapath
- mem_req  out  1  memory read request
- mem_addr  out  32  read address
- mem_rdata  in  32  read data, valid when mem_ack=1
- mem_ack  in  1  read completion
- op  out  3  ALU op
- form  out  1  ALU form
- vec  out  2  vector mode
- alu_config  out  4  ALU config
- A, B, C, D  out  4 each  source register indices
- Y1, Y2  out  4 each  destination register indices
- write  out  2  destination write enables; nonzero only in EXEC
- const_c  out  1  constant-present flag
- pc_inc  out  1  PC increment pulse
- constant  out  32  immediate
- copy_select  out  4  copy select
- issue  out  1  one-cycle pulse in EXEC
- fault  out  1  sticky memory-timeout flag

Behaviour:
- Instruction format:
  - W0: op[31:29], form[28], vec[27:26], write[25:24], const_c[23], alu_config[22:19], copy_select[18:15]; [14:0] ignored.
  - W1: A[31:28], B[27:24], C[23:20], D[19:16], Y1[15:12], Y2[11:8]; [7:0] ignored.
  - W2 (only if const_c): constant.
- States: F0_REQ, F0_INC, F1_REQ, F1_INC, K_REQ, K_INC, EXEC, HALT.
- Reset (async, rst_n=0):
  - state goes to F0_REQ.
  - All outputs go to 0, including constant, fault and the timeout counter.
- REQ states:
  - mem_req=1 and mem_addr=program_counter; F0_REQ does this only when run=1.
  - F0_REQ with run=0: mem_req=0, state holds.
  - mem_ack is sampled on the clk edge while mem_req=1. On ack, the word is latched into its field registers and the state advances to the matching INC state.
- INC states: pc_inc=1 for exactly one cycle; mem_req=0.
  - F0_INC -> F1_REQ.
  - F1_INC -> K_REQ if the latched const_c=1, else EXEC.
  - K_INC -> EXEC.
- EXEC: write = latched W0 write bits for one cycle; issue=1; pc_inc=0; then -> F0_REQ.
- write=00 in every state except EXEC. This prevents the pc_inc-masked R0 writes from colliding with fetch.
- Field outputs are registered. W0 fields update on W0 ack; W1 fields update on W1 ack. They stay stable through EXEC and until the next W0 ack.
- constant: updated only on W2 ack; keeps its previous value for instructions with const_c=0.
- mem_ack outside a REQ state is ignored. mem_rdata is don't-care when mem_ack=0.
- Minimum latency (mem_ack=1 on the first request cycle, run=1): 5 cycles per instruction without constant, 7 with constant. issue occurs every 5 or 7 cycles back-to-back.
- Timeout (MEM_TIMEOUT>0):
  - Counter clears on entry to each REQ state and increments each cycle mem_req=1 without ack.
  - When it reaches MEM_TIMEOUT: fault<=1, state -> HALT.
  - HALT: mem_req=0, pc_inc=0, write=0; leaves only on reset.
- Ack on the same edge the counter reaches MEM_TIMEOUT: the ack wins and no fault is raised.
- Deasserting run affects only F0_REQ; an instruction in progress completes.
- Reset mid-instruction: the partial instruction is abandoned with no write or pc_inc; fetch restarts at F0_REQ.

Test Plan:
- Reset, run=1, PC=0x10, always-ack memory:
  - W0=0x20000000 (op=1, write=00, const_c=0), W1=0x12345600.
  - Required: mem_addr 0x10 then 0x11, pc_inc pulses on cycles 2 and 4, issue on cycle 5, write=00.
  - Required fields: A=1, B=2, C=3, D=4, Y1=5, Y2=6.
- Constant instruction:
  - W0 with write=11 and const_c=1, W2=0xDEADBEEF.
  - Required: three requests, three pc_inc pulses, constant=0xDEADBEEF, write=11 only on the EXEC cycle (cycle 7).
- Memory wait states:
  - mem_ack delayed 3 cycles on W1.
  - Required: mem_req and mem_addr held stable for 4 cycles, no pc_inc during the wait, issue at cycle 8.
- Timeout:
  - MEM_TIMEOUT=4, memory never acks.
  - Required: fault=1 after 4 request cycles, then mem_req=0 permanently; rst_n low clears fault.
- run control and reset:
  - run=0 at F0_REQ: mem_req stays 0 indefinitely.
  - rst_n pulsed low during F1_REQ: all outputs 0 immediately, no issue.
  - Required: after reset release with run=1, fetch resumes at the current PC.
